// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: opcode/funct encodings, the 30-bit control
// word layout and the instruction decode lookup.
package cpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned CTRL_W   = 30;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned SECOND_W = 5;
  localparam int unsigned ALUOP_W  = 6;

  // Primary opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_FPU   = 6'b010001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_READF = 6'b111100;
  localparam logic [OP_W-1:0] OP_READI = 6'b111101;
  localparam logic [OP_W-1:0] OP_OUTC  = 6'b111110;

  // R-type function code (instr[5:0])
  localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'b001000;

  // Legal FPU format range in the second field (instr[25:21])
  localparam logic [SECOND_W-1:0] FMT_LO = 5'b10000;
  localparam logic [SECOND_W-1:0] FMT_HI = 5'b10100;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 6'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 6'd2;

  // Control word, MSB first
  typedef struct packed {
    logic               regwrite;
    logic               regdst;
    logic               alusrc;
    logic               branch;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
    logic               rawrite;
    logic               soru;
    logic               out;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         regaorf1;
    logic [1:0]         regaorf2;
    logic [2:0]         rf3flag;
    logic [2:0]         aorf;
    logic [1:0]         bsltiflag;
    logic [1:0]         readflag;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
  } dec_t;

  // Pure table lookup; unknown encodings give an all-zero word plus illegal.
  function automatic dec_t decode(input logic [OP_W-1:0]     op,
                                  input logic [FUNCT_W-1:0]  funct,
                                  input logic [SECOND_W-1:0] second);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          d.ctrl.jump     = 1'b1;
          d.ctrl.regaorf1 = 2'b01;
        end else begin
          d.ctrl.regwrite = 1'b1;
          d.ctrl.regdst   = 1'b1;
          d.ctrl.aluop    = funct;
        end
      end
      OP_J: d.ctrl.jump = 1'b1;
      OP_JAL: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.jump     = 1'b1;
        d.ctrl.rawrite  = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch    = 1'b1;
        d.ctrl.aluop     = ALUOP_SUB;
        d.ctrl.bsltiflag = 2'b01;
      end
      OP_ADDI: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.soru     = 1'b1;
        d.ctrl.aluop    = ALUOP_ADD;
      end
      OP_LW: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.memtoreg = 1'b1;
        d.ctrl.soru     = 1'b1;
        d.ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        d.ctrl.memwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.soru     = 1'b1;
        d.ctrl.aluop    = ALUOP_ADD;
      end
      OP_FPU: begin
        if (second >= FMT_LO && second <= FMT_HI) begin
          d.ctrl.regwrite = 1'b1;
          d.ctrl.aluop    = {1'b1, second};
          d.ctrl.regaorf1 = 2'b10;
          d.ctrl.regaorf2 = 2'b10;
          d.ctrl.rf3flag  = 3'b001;
          d.ctrl.aorf     = 3'b001;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OP_READF: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.aorf     = 3'b010;
      end
      OP_READI: d.ctrl.regwrite = 1'b1;
      OP_OUTC: begin
        d.ctrl.out      = 1'b1;
        d.ctrl.regaorf1 = 2'b01;
      end
      default: d.illegal = 1'b1;
    endcase
    // readflag tracks the read opcodes regardless of the rest of the table
    d.ctrl.readflag = {op == OP_READF, op == OP_READI};
    return d;
  endfunction

endpackage

// File: rtl/decode_buf.sv
// Payload-generic main + skid register pair with valid/ready handshake.
// Ports:
//   clk, rstn          clock, async active-low reset
//   in_valid/in_ready  upstream handshake (in_ready is a flop when USE_SKID=1)
//   in_data            payload to capture
//   flush              drop all held entries next cycle, discard same-cycle accept
//   fire               head entry consumed this cycle
//   m_valid/m_data     head entry (main register)
module decode_buf #(
  parameter int unsigned DATA_W   = 8,
  parameter bit          USE_SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              fire,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              m_valid_n;
  logic              s_valid_n;
  logic [DATA_W-1:0] m_data_n;
  logic [DATA_W-1:0] s_data_n;
  logic              accept;

  // Handshake: skid build backs off only when the skid slot is occupied
  always_comb begin
    in_ready = 1'b0;
    if (USE_SKID) in_ready = ~s_valid;
    else          in_ready = ~m_valid | fire;
    accept = in_valid & in_ready & ~flush;
  end

  // Next-state for both slots; skid data moves into main, never re-decoded
  always_comb begin
    m_valid_n = m_valid;
    s_valid_n = s_valid;
    m_data_n  = m_data;
    s_data_n  = s_data;
    if (flush) begin
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else if (USE_SKID) begin
      if (fire && s_valid) begin
        m_data_n  = s_data;
        s_valid_n = 1'b0;
      end else if (m_valid && !fire) begin
        if (accept) begin
          s_data_n  = in_data;
          s_valid_n = 1'b1;
        end
      end else begin
        m_valid_n = accept;
        if (accept) m_data_n = in_data;
      end
    end else begin
      if (accept) begin
        m_valid_n = 1'b1;
        m_data_n  = in_data;
      end else if (fire) begin
        m_valid_n = 1'b0;
      end
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else begin
      m_valid <= m_valid_n;
      s_valid <= s_valid_n;
      m_data  <= m_data_n;
      s_data  <= s_data_n;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, back-pressured instruction decode stage between fetch and
// register-read. Decodes each accepted instruction into ctrl_t, buffers it,
// and holds I/O instructions until their RX word / TX slot is available.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc  fetch side
//   flush                             kill all held entries (redirect)
//   rx_valid/rx_pop                   receive buffer status / consume pulse
//   tx_ready/tx_push                  transmit buffer status / outc pulse
//   out_valid/out_ready               downstream handshake
//   out_ctrl/out_instr/out_pc         decoded head entry
//   out_illegal                       head entry not in the decode table
//   stall_cnt                         saturating count of I/O wait cycles
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned CNT_W    = 16,
  parameter bit          USE_SKID = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  input  logic               rx_valid,
  output logic               rx_pop,
  input  logic               tx_ready,
  output logic               tx_push,
  output logic               out_valid,
  input  logic               out_ready,
  output ctrl_t              out_ctrl,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned ENTRY_W = CTRL_W + 1 + INSTR_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    ctrl_t              ctrl;
    logic               illegal;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  dec_t          in_dec;
  entry_t        in_entry;
  entry_t        head;
  logic          head_valid;
  logic [OP_W-1:0] head_op;
  logic          io_rd;
  logic          io_wr;
  logic          present;
  logic          fire;

  // Decode at capture time so the buffer holds ready-made control words
  always_comb begin
    in_dec   = decode(in_instr[31:26], in_instr[5:0], in_instr[25:21]);
    in_entry = '{ctrl: in_dec.ctrl, illegal: in_dec.illegal, instr: in_instr, pc: in_pc};
  end

  decode_buf #(
    .DATA_W   (ENTRY_W),
    .USE_SKID (USE_SKID)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .flush    (flush),
    .fire     (fire),
    .m_valid  (head_valid),
    .m_data   (head)
  );

  // Head presentation: I/O entries wait for their buffer to be usable
  always_comb begin
    head_op     = head.instr[31:26];
    io_rd       = (head_op == OP_READI) || (head_op == OP_READF);
    io_wr       = (head_op == OP_OUTC);
    present     = head_valid & (~(io_rd | io_wr) | (io_rd & rx_valid) | (io_wr & tx_ready));
    fire        = present & out_ready;
    out_valid   = present;
    rx_pop      = fire & io_rd;
    tx_push     = fire & io_wr;
    out_ctrl    = head.ctrl;
    out_illegal = head.illegal;
    out_instr   = head.instr;
    out_pc      = head.pc;
  end

  // I/O wait counter; survives flush, saturates at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (head_valid && !present && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a skid build (CNT_W=16) and a single-register build
// (CNT_W=3, to reach counter saturation) driven by the same stimulus, each
// compared cycle by cycle against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        rx_valid;
  logic        tx_ready;
  logic        out_ready;

  logic        in_ready0, rx_pop0, tx_push0, out_valid0, out_illegal0;
  logic [29:0] out_ctrl0;
  logic [31:0] out_instr0, out_pc0;
  logic [15:0] stall_cnt0;
  logic        in_ready1, rx_pop1, tx_push1, out_valid1, out_illegal1;
  logic [29:0] out_ctrl1;
  logic [31:0] out_instr1, out_pc1;
  logic [2:0]  stall_cnt1;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .CNT_W(16), .USE_SKID(1'b1)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rx_valid(rx_valid), .rx_pop(rx_pop0), .tx_ready(tx_ready), .tx_push(tx_push0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
    .out_instr(out_instr0), .out_pc(out_pc0), .out_illegal(out_illegal0),
    .stall_cnt(stall_cnt0));

  decode_stage #(.PC_W(32), .CNT_W(3), .USE_SKID(1'b0)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rx_valid(rx_valid), .rx_pop(rx_pop1), .tx_ready(tx_ready), .tx_push(tx_push1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_instr(out_instr1), .out_pc(out_pc1), .out_illegal(out_illegal1),
    .stall_cnt(stall_cnt1));

  // Control word bit positions (LSB of each field)
  localparam int P_RW = 29, P_RD = 28, P_AS = 27, P_BR = 26, P_MW = 25, P_MR = 24;
  localparam int P_JP = 23, P_RA = 22, P_SU = 21, P_OUT = 20, P_ALU = 14;
  localparam int P_RA1 = 12, P_RA2 = 10, P_RF3 = 7, P_AORF = 4, P_BSL = 2, P_RDF = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  int unsigned st0 = 0;
  int unsigned st1 = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] pc_ctr = 32'h1000;
  logic [5:0]  op_tab [0:13];

  task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL dut%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] f(input int pos, input int val);
    return 30'(val) << pos;
  endfunction

  // Returns {illegal, ctrl} from the decode table
  function automatic logic [30:0] ref_dec(input logic [31:0] ins);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sec;
    logic [29:0] c;
    logic        ill;
    op = ins[31:26]; fn = ins[5:0]; sec = ins[25:21];
    c = '0; ill = 1'b0;
    case (op)
      6'b000000: c = (fn == 6'b001000) ? (f(P_JP, 1) | f(P_RA1, 1))
                                       : (f(P_RW, 1) | f(P_RD, 1) | f(P_ALU, int'(fn)));
      6'b000010: c = f(P_JP, 1);
      6'b000011: c = f(P_RW, 1) | f(P_JP, 1) | f(P_RA, 1);
      6'b000100: c = f(P_BR, 1) | f(P_ALU, 2) | f(P_BSL, 1);
      6'b001000: c = f(P_RW, 1) | f(P_AS, 1) | f(P_SU, 1) | f(P_ALU, 1);
      6'b100011: c = f(P_RW, 1) | f(P_AS, 1) | f(P_MR, 1) | f(P_SU, 1) | f(P_ALU, 1);
      6'b101011: c = f(P_MW, 1) | f(P_AS, 1) | f(P_SU, 1) | f(P_ALU, 1);
      6'b010001: begin
        if (int'(sec) >= 16 && int'(sec) <= 20)
          c = f(P_RW, 1) | f(P_ALU, 32 + int'(sec)) | f(P_RA1, 2) | f(P_RA2, 2)
            | f(P_RF3, 1) | f(P_AORF, 1);
        else ill = 1'b1;
      end
      6'b111100: c = f(P_RW, 1) | f(P_AORF, 2) | f(P_RDF, 2);
      6'b111101: c = f(P_RW, 1) | f(P_RDF, 1);
      6'b111110: c = f(P_OUT, 1) | f(P_RA1, 1);
      default:   ill = 1'b1;
    endcase
    return {ill, c};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] sec, input logic [5:0] fn);
    return {op, sec, 15'($urandom), fn};
  endfunction

  // Compare one DUT with its model for the current inputs, then advance the model
  task automatic eval(input int d);
    ent_t        h;
    int unsigned sz, mx;
    bit          hv, pres, fr, rdy, iord, iowr;
    logic [30:0] dc;
    logic        ov, ir, rp, tp, il;
    logic [29:0] oc;
    logic [31:0] oi, op;
    logic [15:0] sc;
    h = '{instr: '0, pc: '0};
    if (d == 0) begin
      sz = q0.size(); if (sz != 0) h = q0[0]; mx = 65535;
      ov = out_valid0; ir = in_ready0; rp = rx_pop0; tp = tx_push0; il = out_illegal0;
      oc = out_ctrl0; oi = out_instr0; op = out_pc0; sc = stall_cnt0;
    end else begin
      sz = q1.size(); if (sz != 0) h = q1[0]; mx = 7;
      ov = out_valid1; ir = in_ready1; rp = rx_pop1; tp = tx_push1; il = out_illegal1;
      oc = out_ctrl1; oi = out_instr1; op = out_pc1; sc = 16'(stall_cnt1);
    end
    hv   = (sz != 0);
    iord = hv && (h.instr[31:26] == 6'b111101 || h.instr[31:26] == 6'b111100);
    iowr = hv && (h.instr[31:26] == 6'b111110);
    pres = hv && (iord ? rx_valid : (iowr ? tx_ready : 1'b1));
    fr   = pres && out_ready;
    rdy  = (d == 0) ? (sz < 2) : (sz == 0 || fr);
    chk(d, "out_valid", 64'(ov), 64'(pres));
    chk(d, "in_ready", 64'(ir), 64'(rdy));
    chk(d, "rx_pop", 64'(rp), 64'(fr && iord));
    chk(d, "tx_push", 64'(tp), 64'(fr && iowr));
    chk(d, "stall_cnt", 64'(sc), 64'((d == 0) ? st0 : st1));
    if (pres) begin
      dc = ref_dec(h.instr);
      chk(d, "out_ctrl", 64'(oc), 64'(dc[29:0]));
      chk(d, "out_illegal", 64'(il), 64'(dc[30]));
      chk(d, "out_instr", 64'(oi), 64'(h.instr));
      chk(d, "out_pc", 64'(op), 64'(h.pc));
    end
    if (d == 0) begin
      if (flush) q0.delete();
      else begin
        if (fr) void'(q0.pop_front());
        if (in_valid && rdy) q0.push_back('{instr: in_instr, pc: in_pc});
      end
      if (hv && !pres && st0 < mx) st0++;
    end else begin
      if (flush) q1.delete();
      else begin
        if (fr) void'(q1.pop_front());
        if (in_valid && rdy) q1.push_back('{instr: in_instr, pc: in_pc});
      end
      if (hv && !pres && st1 < mx) st1++;
    end
  endtask

  // One clock cycle: drive at negedge, check 1ns later, step to next negedge
  task automatic cyc(input bit iv, input logic [31:0] ins, input bit ordy,
                     input bit rxv, input bit txr, input bit fl);
    in_valid = iv; in_instr = ins; in_pc = pc_ctr; out_ready = ordy;
    rx_valid = rxv; tx_ready = txr; flush = fl;
    #1;
    eval(0);
    eval(1);
    if (iv) pc_ctr = pc_ctr + 32'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  rop;
    op_tab = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b001000, 6'b100011, 6'b101011,
               6'b010001, 6'b111100, 6'b111101, 6'b111110, 6'b110110, 6'b000000, 6'b001000};
    rstn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    rx_valid = 1'b0; tx_ready = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // Reset state
    chk(0, "rst_out_valid", 64'(out_valid0), 64'(0));
    chk(0, "rst_in_ready", 64'(in_ready0), 64'(1));
    chk(0, "rst_stall_cnt", 64'(stall_cnt0), 64'(0));
    chk(0, "rst_out_ctrl", 64'(out_ctrl0), 64'(0));
    chk(0, "rst_out_instr", 64'(out_instr0), 64'(0));
    chk(0, "rst_out_pc", 64'(out_pc0), 64'(0));
    chk(1, "rst_out_valid", 64'(out_valid1), 64'(0));
    chk(1, "rst_in_ready", 64'(in_ready1), 64'(1));
    @(negedge clk);
    rstn = 1'b1;

    // Streaming plain instructions at full throughput
    cyc(1, mk(6'b001000, 5'd3, 6'd9), 1, 0, 0, 0);
    cyc(1, mk(6'b100011, 5'd4, 6'd1), 1, 0, 0, 0);
    cyc(1, mk(6'b000100, 5'd5, 6'd2), 1, 0, 0, 0);
    cyc(1, mk(6'b000000, 5'd6, 6'b100000), 1, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    chk(0, "t1_stall_cnt", 64'(stall_cnt0), 64'(0));

    // Back-pressure: skid build fills after two entries
    cyc(1, mk(6'b001000, 5'd1, 6'd0), 0, 0, 0, 0);
    cyc(1, mk(6'b100011, 5'd2, 6'd0), 0, 0, 0, 0);
    chk(0, "t2_in_ready_full", 64'(in_ready0), 64'(0));
    cyc(1, mk(6'b101011, 5'd3, 6'd0), 0, 0, 0, 0);
    repeat (3) cyc(0, '0, 1, 0, 0, 0);

    // readi waits five cycles for RX data
    cyc(1, mk(6'b111101, 5'd0, 6'd0), 1, 0, 0, 0);
    repeat (5) cyc(0, '0, 1, 0, 0, 0);
    chk(0, "t3_stall_cnt", 64'(stall_cnt0), 64'(5));
    chk(0, "t3_out_valid_wait", 64'(out_valid0), 64'(0));
    cyc(0, '0, 1, 1, 0, 0);
    cyc(0, '0, 1, 1, 0, 0);

    // outc waiting on TX is flushed; same-cycle accept discarded
    cyc(1, mk(6'b111110, 5'd0, 6'd0), 1, 0, 0, 0);
    cyc(1, mk(6'b001000, 5'd7, 6'd0), 1, 0, 0, 1);
    cyc(0, '0, 1, 0, 1, 0);
    chk(0, "t4_out_valid_after_flush", 64'(out_valid0), 64'(0));
    cyc(0, '0, 1, 0, 1, 0);

    // Illegal encodings and jr
    cyc(1, mk(6'b010001, 5'b11111, 6'd0), 1, 0, 0, 0);
    cyc(1, mk(6'b110110, 5'd2, 6'd3), 1, 0, 0, 0);
    cyc(1, mk(6'b010001, 5'b10010, 6'd0), 1, 0, 0, 0);
    cyc(1, mk(6'b000000, 5'd9, 6'b001000), 1, 0, 0, 0);
    chk(0, "t5_jr_ctrl", 64'(out_ctrl0), 64'(30'h0080_1000));
    cyc(0, '0, 1, 0, 0, 0);

    // Async reset mid-stall with entries held
    cyc(1, mk(6'b111101, 5'd0, 6'd0), 1, 0, 0, 0);
    cyc(1, mk(6'b001000, 5'd1, 6'd0), 1, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    rx_valid = 1'b1;
    rstn = 1'b0;
    #1;
    chk(0, "t6_out_valid", 64'(out_valid0), 64'(0));
    chk(0, "t6_in_ready", 64'(in_ready0), 64'(1));
    chk(0, "t6_rx_pop", 64'(rx_pop0), 64'(0));
    chk(0, "t6_stall_cnt", 64'(stall_cnt0), 64'(0));
    chk(1, "t6_out_valid", 64'(out_valid1), 64'(0));
    chk(1, "t6_rx_pop", 64'(rx_pop1), 64'(0));
    q0.delete(); q1.delete(); st0 = 0; st1 = 0;
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      rop = op_tab[$urandom_range(0, 13)];
      ins = mk(rop, 5'($urandom), ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom));
      cyc(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
